// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, bit-timing FSM and a one-entry
// holding register with sticky frame-error and overrun flags for the MMU.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       read_en,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_meta_q, rx_s_q;
  logic            load, ferr_set;

  // Flops reset to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load      = 1'b0;
    ferr_set  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            load    = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitIdle: begin
        // A held-low (break) line must go high before a new start bit is accepted.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // A load in the same cycle as read_en wins: the new byte stays valid, flags clear.
  always_comb begin
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = frame_err_q;

    if (load) begin
      data_d       = shift_q;
      data_valid_d = 1'b1;
    end else if (read_en) begin
      data_valid_d = 1'b0;
    end

    if (load && data_valid_q && !read_en) begin
      overrun_d = 1'b1;
    end else if (read_en) begin
      overrun_d = 1'b0;
    end

    if (ferr_set) begin
      frame_err_d = 1'b1;
    end else if (read_en) begin
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes; a negedge
// monitor pops and checks each byte as it appears in the holding register.
module tb_uart_rx;

  localparam int unsigned Cpb     = 16;
  localparam int unsigned Half    = Cpb / 2;
  localparam int unsigned LoadOff = 3 + Half + 9 * Cpb;  // rx fall to load edge

  typedef struct {
    logic [7:0]  d;
    logic        ov;
    logic        fe;
    int unsigned at;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       read_en;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc_cnt  = 0;
  exp_t        exp_q[$];
  exp_t        e;
  logic        prev_valid = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .read_en   (read_en),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // A new byte is presented when valid rises or the held byte is replaced.
  always @(negedge clk) begin
    if (rst && data_valid && (!prev_valid || data != prev_data)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: actual=%0h required=none", data);
      end else begin
        e = exp_q.pop_front();
        check("byte_data", 32'(data), 32'(e.d));
        check("byte_overrun", 32'(overrun), 32'(e.ov));
        check("byte_frame_err", 32'(frame_err), 32'(e.fe));
        check("byte_cycle", cyc_cnt, e.at);
      end
    end
    prev_valid <= data_valid;
    prev_data  <= data;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ncyc,
                            input bit push, input logic ov, input logic fe, input bit rd_at_load);
    logic [9:0] frame;
    exp_t       x;
    frame = {stop_bit, b, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0 && push) begin
        x.d  = b;
        x.ov = ov;
        x.fe = fe;
        x.at = cyc_cnt + LoadOff;
        exp_q.push_back(x);
      end
      rx      = frame[c / Cpb];
      read_en = rd_at_load && (c == int'(LoadOff) - 1);
    end
    read_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic pulse_read();
    @(negedge clk);
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    rx      = 1'b1;
    read_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_flags", 32'({frame_err, overrun}), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    rst = 1'b1;
    idle(5);

    // 1: basic frame with exact latency
    send_frame(8'h55, 1'b1, 10 * Cpb, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("t1_busy_after", 32'(rx_busy), 32'd0);
    check("t1_valid_held", 32'(data_valid), 32'd1);
    pulse_read();
    check("t1_valid_cleared", 32'(data_valid), 32'd0);

    // 2: short glitch rejected, then a good frame
    send_frame(8'h00, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("t2_busy_glitch", 32'(rx_busy), 32'd1);
    idle(20);
    check("t2_busy_idle", 32'(rx_busy), 32'd0);
    check("t2_no_valid", 32'(data_valid), 32'd0);
    check("t2_no_flags", 32'({frame_err, overrun}), 32'd0);
    send_frame(8'hC3, 1'b1, 10 * Cpb, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    pulse_read();

    // 3: back-to-back frames without a read cause overrun
    send_frame(8'hA5, 1'b1, 10 * Cpb, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 10 * Cpb, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("t3_overrun", 32'(overrun), 32'd1);
    pulse_read();
    check("t3_valid_cleared", 32'(data_valid), 32'd0);
    check("t3_overrun_cleared", 32'(overrun), 32'd0);
    check("t3_data_kept", 32'(data), 32'h3C);

    // 4: bad stop bit followed by a held-low line
    send_frame(8'hFF, 1'b0, 10 * Cpb, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) begin
      @(negedge clk);
      rx = 1'b0;
    end
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check("t4_no_valid", 32'(data_valid), 32'd0);
    check("t4_busy_low", 32'(rx_busy), 32'd1);
    idle(5);
    check("t4_busy_released", 32'(rx_busy), 32'd0);
    send_frame(8'h12, 1'b1, 10 * Cpb, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("t4_frame_err_sticky", 32'(frame_err), 32'd1);
    pulse_read();
    check("t4_frame_err_cleared", 32'(frame_err), 32'd0);

    // 5: asynchronous reset during data bit 3
    send_frame(8'h99, 1'b1, 64, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_busy_before", 32'(rx_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_data", 32'(data), 32'h00);
    check("t5_rst_valid", 32'(data_valid), 32'd0);
    check("t5_rst_flags", 32'({frame_err, overrun}), 32'd0);
    check("t5_rst_busy", 32'(rx_busy), 32'd0);
    idle(3);
    rst = 1'b1;
    idle(5);
    send_frame(8'h81, 1'b1, 10 * Cpb, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    // 6: read_en coincides with the next load
    send_frame(8'h7E, 1'b1, 10 * Cpb, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("t6_valid", 32'(data_valid), 32'd1);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_data", 32'(data), 32'h7E);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the existing transmitter on the same serial line format.
- Samples the asynchronous serial input and deserialises one byte per frame.
- Presents the byte in a one-entry holding register with valid and error flags for the MMU to read at a memory-mapped status/data location.
- Sits in the top level beside the transmitter, on the same system clock.

Parameters:
- CLKS_PER_BIT, 434, system clock cycles per bit period (50 MHz / 115200 baud); must be >= 8.
- HALF_BIT, CLKS_PER_BIT/2, start-bit validation point in cycles; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial input pin; idle high; asynchronous to clk.
- read_en  input  1  one-cycle pulse from MMU; consumes the held byte and clears flags.
- data  output  8  last received byte.
- data_valid  output  1  holding register contains an unread byte.
- frame_err  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a byte arrived while data_valid was still set.
- rx_busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- **Reset.** rst low immediately forces:
  - state=IDLE; all counters 0.
  - data=0x00; data_valid, frame_err, overrun and rx_busy all 0.
  - Both synchronizer flops to 1.
  - Reset mid-frame abandons the frame with no partial output.
- **Synchronizer.** rx passes through two flops; rx_s is the second flop. All decisions use rx_s only.
- **Counter.** cnt (width clog2(CLKS_PER_BIT)):
  - Increments every cycle in START/DATA/STOP.
  - Clears to 0 on every state transition and on each bit boundary.
- **State machine:**
  - IDLE: rx_s==0 -> START (cnt=0).
  - START:
    - At cnt==HALF_BIT-1, if rx_s==0 -> DATA (cnt=0, bit_idx=0).
    - Otherwise treat as a glitch -> IDLE; no flag is set.
  - DATA:
    - At cnt==CLKS_PER_BIT-1, shift rx_s in LSB-first and clear cnt.
    - After bit_idx==7 is sampled -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1: load the shift register into data, set data_valid=1 -> IDLE.
    - rx_s==0: set frame_err=1, discard the byte (data and data_valid unchanged) -> WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1 -> IDLE. This prevents a break/held-low line from being taken as a new start bit.
- **Latency.** Let T0 be the first cycle IDLE sees rx_s==0. Then:
  - data_valid is high from cycle T0+1+HALF_BIT+9*CLKS_PER_BIT.
  - Relative to the rx pin falling edge, add 2 cycles for synchronizer delay.
- **Holding register and flags:**
  - read_en alone: data_valid, overrun and frame_err clear on the next edge; data is retained.
  - Load while data_valid==1 and no read_en in the same cycle: data is overwritten, overrun=1, data_valid stays 1.
  - Load and read_en in the same cycle: the load wins; data_valid=1, data=new byte, overrun not set, error flags cleared.
  - frame_err set and read_en in the same cycle: frame_err=1 (set wins).
  - read_en while data_valid==0: clears the flags; otherwise has no effect.
- **rx_busy** is combinational from state (state != IDLE), so it is 0 in reset.
- **Reception is never stalled** by an unread byte; the receiver keeps running.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8):
1. Drive frame 0x55 (start 0, bits LSB-first, stop 1) -> data=0x55, data_valid=1 exactly at T0+1+8+144, frame_err=0, overrun=0, rx_busy=0 afterwards.
2. Pull rx low for 4 cycles, then high -> rx_busy pulses, returns to IDLE, data_valid stays 0, no flags set; a following 0xC3 frame is received correctly.
3. Send 0xA5 then 0x3C back-to-back with no read_en -> data=0x3C, data_valid=1, overrun=1. Pulse read_en -> next cycle data_valid=0, overrun=0, data=0x3C.
4. Send 0xFF with the stop bit at 0, then hold rx low 40 cycles -> frame_err=1, data_valid=0, rx_busy=1 while low. Release rx high, then send 0x12 -> data=0x12, data_valid=1, frame_err still 1 until read_en.
5. Assert rst low during DATA bit 3 of a frame -> same-cycle (asynchronous) data=0, flags 0, rx_busy=0. Release rst, send 0x81 -> data=0x81, data_valid=1.
6. Hold data_valid=1, then assert read_en on the exact cycle the next byte 0x7E loads -> data=0x7E, data_valid=1, overrun=0.
